// File: rtl/bcd_counter_n.sv
// Parametrised N-digit BCD up/down counter with clear, load, saturate/wrap mode and wrap pulse.
// Optional macro BCD_LOAD_CHECK_EN rejects loads with nibbles > 9 (else such nibbles clamp to 9).
module bcd_counter_n #(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic                up,
  input  logic                sat,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                wrap,
  output logic                at_max,
  output logic                at_min,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] count_q, count_d;
  logic [W-1:0] inc_val, dec_val;
  logic         wrap_q, wrap_d;
  logic         load_err_q, load_err_d;
  logic         all_nines, all_zero;
`ifdef BCD_LOAD_CHECK_EN
  logic         load_bad;
`else
  logic [W-1:0] load_fix;
`endif

  // Ripple the carry/borrow through the digits: a digit steps only when all lower digits roll.
  always_comb begin : step_calc
    logic       carry;
    logic       borrow;
    logic [3:0] dig;
    // NOTE: every variable driven here gets a default up front, so no path can infer a latch;
    // blocking assignments are correct in combinational logic (and only there).
    inc_val = count_q;
    dec_val = count_q;
    carry   = 1'b1;
    borrow  = 1'b1;
    dig     = 4'd0;
`ifdef BCD_LOAD_CHECK_EN
    load_bad = 1'b0;
`else
    load_fix = load_val;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      dig = count_q[4*i +: 4];
      if (carry)
        inc_val[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
      if (borrow)
        dec_val[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
      carry  = carry && (dig == 4'd9);
      borrow = borrow && (dig == 4'd0);
`ifdef BCD_LOAD_CHECK_EN
      if (load_val[4*i +: 4] > 4'd9)
        load_bad = 1'b1;
`else
      if (load_val[4*i +: 4] > 4'd9)
        load_fix[4*i +: 4] = 4'd9;
`endif
    end
    all_nines = carry;
    all_zero  = borrow;
  end

  always_comb begin : next_state
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
`ifdef BCD_LOAD_CHECK_EN
      if (load_bad)
        load_err_d = 1'b1;
      else
        count_d = load_val;
`else
      count_d = load_fix;
`endif
    end else if (en) begin
      if (up) begin
        if (!all_nines) begin
          count_d = inc_val;
        end else if (!sat) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        if (!all_zero) begin
          count_d = dec_val;
        end else if (!sat) begin
          count_d = {DIGITS{4'd9}};
          wrap_d  = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign at_max   = all_nines;
  assign at_min   = all_zero;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed self-checking bench for bcd_counter_n: a 2-digit and a 3-digit instance share controls.
module tb_bcd_counter_n;

  logic        clk = 1'b0;
  logic        rst, clr, en, up, sat, load;
  logic [7:0]  load_val2;
  logic [11:0] load_val3;
  logic [7:0]  count2;
  logic [11:0] count3;
  logic        wrap2, at_max2, at_min2, load_err2;
  logic        wrap3, at_max3, at_min3, load_err3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_counter_n #(.DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val2), .count(count2), .wrap(wrap2), .at_max(at_max2),
    .at_min(at_min2), .load_err(load_err2)
  );

  bcd_counter_n #(.DIGITS(3)) dut3 (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val3), .count(count3), .wrap(wrap3), .at_max(at_max3),
    .at_min(at_min3), .load_err(load_err3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_cnt;
    rst = 1'b1; clr = 1'b0; en = 1'b0; up = 1'b1; sat = 1'b0; load = 1'b0;
    load_val2 = 8'h00; load_val3 = 12'h000;

    // Reset state
    tick();
    check("rst_count", {24'd0, count2}, 32'h00);
    check("rst_wrap", {31'd0, wrap2}, 32'd0);
    check("rst_at_min", {31'd0, at_min2}, 32'd1);
    check("rst_at_max", {31'd0, at_max2}, 32'd0);
    check("rst_load_err", {31'd0, load_err2}, 32'd0);
    rst = 1'b0;

    // 1: full up-count 00..99 then wrap to 00
    en = 1'b1; up = 1'b1; sat = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      exp_cnt = {4'((i % 100) / 10), 4'(i % 10)};
      check("up_count", {24'd0, count2}, {24'd0, exp_cnt});
      check("up_wrap", {31'd0, wrap2}, {31'd0, (i == 100)});
      check("up_at_max", {31'd0, at_max2}, {31'd0, (i == 99)});
    end

    // 2: load 40, count down across the tens boundary, then down-wrap from 00
    en = 1'b0; load = 1'b1; load_val2 = 8'h40;
    tick();
    check("load40", {24'd0, count2}, 32'h40);
    load = 1'b0; en = 1'b1; up = 1'b0;
    tick();
    check("dn39", {24'd0, count2}, 32'h39);
    tick();
    check("dn38", {24'd0, count2}, 32'h38);
    check("dn38_wrap", {31'd0, wrap2}, 32'd0);
    load = 1'b1; load_val2 = 8'h00;
    tick();
    check("load00", {24'd0, count2}, 32'h00);
    load = 1'b0;
    tick();
    check("dn_wrap_count", {24'd0, count2}, 32'h99);
    check("dn_wrap_pulse", {31'd0, wrap2}, 32'd1);
    check("dn_wrap_at_max", {31'd0, at_max2}, 32'd1);
    en = 1'b0;
    tick();
    check("dn_wrap_hold", {24'd0, count2}, 32'h99);
    check("dn_wrap_pulse_end", {31'd0, wrap2}, 32'd0);

    // 3: 3-digit saturate at both ends
    sat = 1'b1; load = 1'b1; load_val3 = 12'h999; load_val2 = 8'h99;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sat_hi_count", {20'd0, count3}, 32'h999);
      check("sat_hi_wrap", {31'd0, wrap3}, 32'd0);
    end
    check("sat_hi_at_max", {31'd0, at_max3}, 32'd1);
    en = 1'b0; load = 1'b1; load_val3 = 12'h000; load_val2 = 8'h00;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("sat_lo_count", {20'd0, count3}, 32'h000);
      check("sat_lo_wrap", {31'd0, wrap3}, 32'd0);
    end
    check("sat_lo_at_min", {31'd0, at_min3}, 32'd1);

    // 4: priority clr > load > en, then rst over load, then rst discards a due wrap
    sat = 1'b0; en = 1'b0; load = 1'b1; load_val2 = 8'h57;
    tick();
    check("prio_load57", {24'd0, count2}, 32'h57);
    clr = 1'b1; load = 1'b1; en = 1'b1; up = 1'b1; load_val2 = 8'h12;
    tick();
    check("prio_clr", {24'd0, count2}, 32'h00);
    clr = 1'b0; rst = 1'b1;
    tick();
    check("prio_rst_count", {24'd0, count2}, 32'h00);
    check("prio_rst_wrap", {31'd0, wrap2}, 32'd0);
    rst = 1'b0; load = 1'b1; en = 1'b0; load_val2 = 8'h99;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1; rst = 1'b1;
    tick();
    check("rst_drop_wrap_count", {24'd0, count2}, 32'h00);
    check("rst_drop_wrap_pulse", {31'd0, wrap2}, 32'd0);
    rst = 1'b0; en = 1'b0;

    // 5: invalid load nibble
    load = 1'b1; load_val2 = 8'h25;
    tick();
    load_val2 = 8'h3A;
    tick();
`ifdef BCD_LOAD_CHECK_EN
    check("bad_load_count", {24'd0, count2}, 32'h25);
    check("bad_load_err", {31'd0, load_err2}, 32'd1);
`else
    check("bad_load_count", {24'd0, count2}, 32'h39);
    check("bad_load_err", {31'd0, load_err2}, 32'd0);
`endif
    load = 1'b0;
    tick();
    check("bad_load_err_end", {31'd0, load_err2}, 32'd0);

    // 6: enable toggling from 18 upward
    load = 1'b1; load_val2 = 8'h18;
    tick();
    load = 1'b0; up = 1'b1; sat = 1'b0;
    en = 1'b1; tick();
    check("en_19a", {24'd0, count2}, 32'h19);
    check("en_wrap_a", {31'd0, wrap2}, 32'd0);
    en = 1'b0; tick();
    check("en_19b", {24'd0, count2}, 32'h19);
    check("en_wrap_b", {31'd0, wrap2}, 32'd0);
    en = 1'b1; tick();
    check("en_20a", {24'd0, count2}, 32'h20);
    check("en_wrap_c", {31'd0, wrap2}, 32'd0);
    en = 1'b0; tick();
    check("en_20b", {24'd0, count2}, 32'h20);
    check("en_wrap_d", {31'd0, wrap2}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_counter_n.md
Name: bcd_counter_n

Overview:
Parametrised multi-digit BCD up/down counter. It generalises the fixed two-digit 00-99 up-counter to N digits, adding direction control, enable, synchronous clear, parallel load, wrap/saturate mode and a wrap pulse. It sits in the counter library and drives display, timer and event-count logic, and can be cascaded through the wrap pulse.

Parameters:
DIGITS, 2, number of BCD digits (1..8); count range 0 .. 10^DIGITS-1.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, synchronous, active-high.
clr  input  1  synchronous clear to 0.
en  input  1  count enable; one step per clk edge while high.
up  input  1  direction: 1 = increment, 0 = decrement.
sat  input  1  mode: 1 = saturate at the limit, 0 = wrap.
load  input  1  parallel load of load_val.
load_val  input  4*DIGITS  BCD load value; digit 0 (least significant) in bits [3:0].
count  output  4*DIGITS  registered BCD count; digit 0 in bits [3:0].
wrap  output  1  registered 1-cycle pulse on a rollover (99..9 to 0, or 0 to 99..9).
at_max  output  1  high when count equals all-nines (decoded from the count register).
at_min  output  1  high when count equals 0 (decoded from the count register).
load_err  output  1  registered 1-cycle pulse when a load is rejected (feature only; otherwise tied 0).

Behaviour:
- Reset: count = 0, wrap = 0, load_err = 0. at_min = 1 and at_max = 0 follow from the count.
- Priority at each edge: rst > clr > load > en. Lower-priority inputs are ignored in that cycle.
- clr: count becomes 0. wrap stays 0.
- load: count becomes load_val, regardless of en. wrap stays 0.
- Latency: a step, clear or load sampled at edge k is visible on count immediately after edge k. No extra output pipeline stage.
- en = 0 with no clr or load: count holds and wrap = 0.
- Up step, per digit i:
  - Digit i increments when every lower digit is 9. Digit 0 always qualifies.
  - A qualifying digit at 9 becomes 0. Otherwise it becomes digit + 1.
- Down step, per digit i:
  - Digit i decrements when every lower digit is 0.
  - A qualifying digit at 0 becomes 9. Otherwise it becomes digit - 1.
- Boundary, up from all-nines:
  - sat = 0: count goes to 0 and wrap pulses high for the cycle following that edge.
  - sat = 1: count holds and wrap = 0.
- Boundary, down from 0:
  - sat = 0: count goes to all-nines and wrap pulses.
  - sat = 1: count holds and wrap = 0.
- wrap is high only for the single cycle after the rollover edge. Back-to-back rollovers (e.g. DIGITS=1, continuous counting) give a pulse on each one.
- Changing up or sat mid-count takes effect on the next enabled edge. There are no internal pending states.
- Asserting rst mid-count discards everything, including a wrap pulse due that cycle; wrap = 0 after the reset edge.
- Every count digit stays in 0..9 at all times (see Optional Feature for invalid load nibbles).

Optional Feature:
Macro BCD_LOAD_CHECK_EN.
- Defined: a load whose load_val contains any nibble > 9 is rejected. count holds, and load_err pulses for one cycle after that edge. Valid loads set load_err = 0.
- Not defined: no rejection; each nibble > 9 is clamped to 9 when loaded; load_err is tied to 0.

Test Plan:
1. DIGITS=2: rst, then en=1, up=1, sat=0 for 100 cycles -> count goes 00,01..09,10..99,00; wrap high only in the cycle count=00 after 99; at_max high at 99.
2. DIGITS=2: load 0x40, then up=0 for 2 edges -> count 39, then 38; load 0x00 with up=0 -> 99 plus one wrap pulse.
3. DIGITS=3, sat=1: load 0x999, up=1 for 3 edges -> count holds 999, wrap stays 0; up=0 from 0x000 -> holds 000, at_min=1.
4. Priority: load=1, clr=1, en=1 at count 0x57 -> count 00; next edge rst=1 with load=1 -> count 00, wrap 0.
5. Invalid load 0x3A, DIGITS=2: with BCD_LOAD_CHECK_EN -> count unchanged, load_err one-cycle pulse; without the macro -> count 0x39, load_err 0.
6. en toggling 1,0,1,0 at 0x18 up -> count 19, 19, 20, 20; wrap 0 throughout.
